// File: rtl/heat_row_render.sv
// heat_row_render: paints one grid row of node amplitudes as SCALE x SCALE RGB332 squares.
module heat_row_render #(
  parameter int NODES    = 64,
  parameter int SCALE    = 4,
  parameter int X_ORIGIN = 0,
  parameter int Y_ORIGIN = 0
) (
  input  logic                  clk_50,
  input  logic                  reset,
  input  logic                  flag,
  input  logic [32*NODES-1:0]   node_bus,
  output logic                  start,
  output logic [9:0]            pix_x,
  output logic [8:0]            pix_y,
  output logic [7:0]            pix_color,
  output logic                  pix_we,
  input  logic                  pix_ready,
  output logic [5:0]            row_idx,
  output logic                  frame_done,
  output logic                  overrun
);
  localparam int NW = NODES > 1 ? $clog2(NODES) : 1;
  localparam int SW = SCALE > 1 ? $clog2(SCALE) : 1;
  typedef enum logic [1:0] {IDLE, CAPTURE, DRAW, FINISH} state_t;
  state_t state;
  logic flag_q, rise;
  logic [NODES-1:0][31:0] shadow;
  logic [SW-1:0] sx, sy, tsx, tsy;
  logic [NW-1:0] n, tn;
  logic last_sx, last_n, last_px;
  logic [9:0] nv;
  logic [4:0] idx;
  logic [7:0] col;
  logic [9:0] tx;
  logic [8:0] ty;
  assign rise = flag & ~flag_q;
  // t* is the pixel to present next: the current one when idle, the successor after an accept
  always_comb begin
    last_sx = sx == SW'(SCALE - 1);
    last_n  = n == NW'(NODES - 1);
    last_px = last_sx && last_n && sy == SW'(SCALE - 1);
    tsx = !pix_we ? sx : last_sx ? '0 : sx + 1'b1;
    tn  = (!pix_we || !last_sx) ? n : last_n ? '0 : n + 1'b1;
    tsy = (!pix_we || !(last_sx && last_n)) ? sy : sy + 1'b1;
    nv  = shadow[tn][31:22];
    idx = nv[9] ? 5'd0 : (|nv[8:5]) ? 5'h1f : nv[4:0];
    col = idx[4:3] == 2'b00 ? {3'b000, idx[2:0], 2'b11} :
          idx[4:3] == 2'b01 ? {6'b000111, ~idx[2:1]} :
          idx[4:3] == 2'b10 ? {idx[2:0], 5'b11100} :
                              {3'b111, ~idx[2:0], 2'b00};
    tx = 10'(X_ORIGIN + int'(tn) * SCALE + int'(tsx));
    ty = 9'(Y_ORIGIN + int'(row_idx) * SCALE + int'(tsy));
  end
  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      flag_q     <= 1'b0;
      shadow     <= '0;
      start      <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      pix_we     <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_color  <= '0;
      row_idx    <= '0;
      sx         <= '0;
      n          <= '0;
      sy         <= '0;
    end else begin
      flag_q     <= flag;
      start      <= 1'b0;
      frame_done <= 1'b0;
      if (rise && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: if (rise) begin
          shadow <= node_bus;
          state  <= CAPTURE;
        end
        CAPTURE: begin
          sx    <= '0;
          n     <= '0;
          sy    <= '0;
          state <= DRAW;
        end
        DRAW: if (!pix_we || pix_ready) begin
          if (pix_we && last_px) begin
            pix_we <= 1'b0;
            state  <= FINISH;
          end else begin
            pix_we    <= 1'b1;
            sx        <= tsx;
            n         <= tn;
            sy        <= tsy;
            pix_x     <= tx;
            pix_y     <= ty;
            pix_color <= col;
          end
        end
        FINISH: begin
          start      <= 1'b1;
          frame_done <= row_idx == 6'(NODES - 1);
          row_idx    <= row_idx == 6'(NODES - 1) ? '0 : row_idx + 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_heat_row_render.sv
// tb_heat_row_render: randomized row rendering checked against a pixel-list model.
module tb_heat_row_render;
  logic clk_50 = 1'b0;
  logic reset, flag, pix_ready, start, pix_we, frame_done, overrun;
  logic [2047:0] node_bus;
  logic [9:0] pix_x;
  logic [8:0] pix_y;
  logic [7:0] pix_color;
  logic [5:0] row_idx;
  int checks = 0, failures = 0, fd_count = 0;
  int ex_x[1024], ex_y[1024], ex_c[1024];
  always #10 clk_50 = ~clk_50;
  heat_row_render dut (
    .clk_50(clk_50), .reset(reset), .flag(flag), .node_bus(node_bus), .start(start),
    .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color), .pix_we(pix_we),
    .pix_ready(pix_ready), .row_idx(row_idx), .frame_done(frame_done), .overrun(overrun)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic int color_of(input logic [31:0] v);
    int idx, f;
    if (v[31]) idx = 0;
    else if (v >= 32'h0800_0000) idx = 255;
    else idx = int'(v >> 19);
    f = (idx % 64) / 8;
    case (idx / 64)
      0: return f * 4 + 3;
      1: return 28 + 3 - (idx % 64) / 16;
      2: return f * 32 + 28;
      default: return 224 + (7 - f) * 4;
    endcase
  endfunction
  function automatic logic [2047:0] rand_nodes();
    logic [2047:0] nb;
    for (int i = 0; i < 64; i++)
      nb[32*i +: 32] = $urandom_range(0, 1) ? ($urandom >> $urandom_range(4, 9)) : $urandom;
    return nb;
  endfunction
  task automatic build(input logic [2047:0] nb, input int row);
    int k = 0;
    for (int sy = 0; sy < 4; sy++)
      for (int n = 0; n < 64; n++)
        for (int sx = 0; sx < 4; sx++) begin
          ex_x[k] = n * 4 + sx;
          ex_y[k] = row * 4 + sy;
          ex_c[k] = color_of(nb[32*n +: 32]);
          k++;
        end
  endtask
  task automatic run_row(input logic [2047:0] nb, input int row, input int rdy_pct,
                         input bit ovr, input int abort_at);
    int k = 0, cyc = 0, first = -1, starts = 0, phase = 0;
    bit stalled = 0;
    logic [27:0] held = '0;
    build(nb, row);
    @(negedge clk_50);
    flag = 1'b0;
    @(negedge clk_50);
    node_bus = nb;
    flag = 1'b1;
    while (cyc < 5000) begin
      @(negedge clk_50);
      cyc++;
      if (stalled) chk("stall_hold", {pix_we, pix_x, pix_y, pix_color}, held);
      if (k == 1024) chk("we_after_last", pix_we, 0);
      if (pix_we && first < 0) begin
        first = cyc;
        chk("latency", cyc, 3);
      end
      chk("frame_done", frame_done, start && row == 63);
      if (frame_done) fd_count++;
      if (start) begin
        starts++;
        chk("start_after_last", k, 1024);
        chk("row_idx_next", row_idx, (row + 1) % 64);
      end else if (starts > 0) break;
      if (k == abort_at) break;
      if (ovr && k >= 300 && phase == 0) begin
        flag = 1'b0;
        phase = 1;
      end else if (phase == 1) begin
        flag = 1'b1;
        node_bus = ~nb;
        phase = 2;
      end
      pix_ready = $urandom_range(0, 99) < rdy_pct;
      if (pix_we && pix_ready) begin
        chk("pix_x", pix_x, ex_x[k]);
        chk("pix_y", pix_y, ex_y[k]);
        chk("pix_color", pix_color, ex_c[k]);
        k++;
      end
      stalled = pix_we && !pix_ready;
      held = {pix_we, pix_x, pix_y, pix_color};
    end
    if (abort_at < 0) chk("start_count", starts, 1);
    else chk("abort_reached", k, abort_at);
  endtask
  initial begin
    logic [2047:0] nb;
    reset = 1'b0;
    flag = 1'b0;
    pix_ready = 1'b0;
    node_bus = '0;
    repeat (3) @(negedge clk_50);
    chk("rst_ctrl", {start, pix_we, frame_done, overrun}, 0);
    chk("rst_addr", {pix_x, pix_y, pix_color}, 0);
    chk("rst_row", row_idx, 0);
    reset = 1'b1;
    run_row('0, 0, 100, 0, -1);
    chk("overrun_clear", overrun, 0);
    chk("row_after_first", row_idx, 1);
    nb = rand_nodes();
    nb[32*5 +: 32] = 32'h0400_0000;
    nb[32*6 +: 32] = 32'hF000_0000;
    nb[32*7 +: 32] = 32'h1000_0000;
    run_row(nb, 1, 50, 0, -1);
    run_row(rand_nodes(), 2, 80, 1, -1);
    chk("overrun_set", overrun, 1);
    repeat (20) begin
      @(negedge clk_50);
      chk("no_extra_row", {start, pix_we}, 0);
    end
    run_row(rand_nodes(), 3, 100, 0, 500);
    reset = 1'b0;
    flag = 1'b0;
    #1;
    chk("abort_we", pix_we, 0);
    chk("abort_outs", {start, frame_done, overrun, pix_x, pix_y, pix_color, row_idx}, 0);
    repeat (3) @(negedge clk_50);
    reset = 1'b1;
    repeat (20) begin
      @(negedge clk_50);
      chk("abort_no_start", {start, pix_we}, 0);
    end
    fd_count = 0;
    for (int r = 0; r < 64; r++) run_row(rand_nodes(), r, 100, 0, -1);
    chk("frame_done_count", fd_count, 1);
    chk("row_wrap", row_idx, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
